// File: rtl/pipelined_select_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready flow control.
//
// Stage 1 precomputes, for every BLK-bit block, the block sum with carry-in 0
// and with carry-in 1 (each BLK+1 bits so the block carry-out is kept).
// Stage 2 walks the block carries from the effective carry-in and picks the
// matching precomputed slice for each block, then registers sum, carry-out and
// signed overflow.
//
// Handshake: a transfer into a stage happens at a rising clock edge when the
// upstream valid and the stage's ready are both high. A stage that holds valid
// data and is not advancing keeps its data unchanged. in_ready depends
// combinationally on out_ready (no skid buffer); nothing else crosses a stage
// without a register.
//
// Legal configurations: BLK >= 1 and WIDTH a whole multiple of BLK.
// BLK == WIDTH collapses to a single block, i.e. a plain pipelined adder.
module pipelined_select_adder #(
  parameter int WIDTH = 24,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NBLK = WIDTH / BLK;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic w_s2_ready;
  logic w_s1_ready;
  logic w_accept;    // input transfer into stage 1 at the next edge
  logic w_advance;   // stage 1 transfer into stage 2 at the next edge

  logic r_s1_valid;
  logic r_out_valid;

  // Ready chain: a stage can load when it is empty or is emptying this cycle.
  always_comb begin
    w_s2_ready = !r_out_valid || out_ready;
    w_s1_ready = !r_s1_valid || w_s2_ready;
    w_accept   = in_valid && w_s1_ready;
    w_advance  = r_s1_valid && w_s2_ready;
  end

  assign in_ready = w_s1_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: effective operands and per-block candidate sums
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]          w_b_eff;
  logic                      w_c_eff;
  logic [NBLK-1:0][BLK:0]    w_s0;
  logic [NBLK-1:0][BLK:0]    w_s1;

  logic [NBLK-1:0][BLK:0]    r_s0;
  logic [NBLK-1:0][BLK:0]    r_s1;
  logic                      r_c_eff;
  logic                      r_a_msb;
  logic                      r_b_msb;

  // Subtraction is A + ~B + ~cin; both block candidates are formed here.
  always_comb begin
    w_b_eff = in_sub ? ~in_b : in_b;
    w_c_eff = in_sub ? ~in_cin : in_cin;
    for (int i = 0; i < NBLK; i++) begin
      w_s0[i] = {1'b0, in_a[i*BLK +: BLK]} + {1'b0, w_b_eff[i*BLK +: BLK]};
      w_s1[i] = {1'b0, in_a[i*BLK +: BLK]} + {1'b0, w_b_eff[i*BLK +: BLK]}
                + (BLK+1)'(1);
    end
  end

  // Stage 1 registers: load on accept, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s0       <= '0;
      r_s1       <= '0;
      r_c_eff    <= 1'b0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s0       <= w_s0;
        r_s1       <= w_s1;
        r_c_eff    <= w_c_eff;
        r_a_msb    <= in_a[WIDTH-1];
        r_b_msb    <= w_b_eff[WIDTH-1];
      end else if (w_advance) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: resolve block carries and select slices
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_out_ovf;

  // Carry ripples block to block; each block carry selects its candidate.
  always_comb begin
    logic v_c;
    w_sum = '0;
    v_c   = r_c_eff;
    for (int i = 0; i < NBLK; i++) begin
      w_sum[i*BLK +: BLK] = v_c ? r_s1[i][BLK-1:0] : r_s0[i][BLK-1:0];
      v_c                 = v_c ? r_s1[i][BLK]     : r_s0[i][BLK];
    end
    w_cout = v_c;
    w_ovf  = (r_a_msb == r_b_msb) && (w_sum[WIDTH-1] != r_a_msb);
  end

  // Output registers: load on stage-1 advance, clear valid when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_advance) begin
        r_out_valid <= 1'b1;
        r_out_sum   <= w_sum;
        r_out_cout  <= w_cout;
        r_out_ovf   <= w_ovf;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_pipelined_select_adder.sv
// Bench for pipelined_select_adder. The main instance (BLK=4) is checked
// through an expected queue; two further instances (BLK=24, BLK=1) receive
// the same stimulus and must present the same results at the same times.
module tb_pipelined_select_adder;

  localparam int W = 24;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic         in_valid = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_ready = 1'b1;

  logic         in_ready, out_valid, out_cout, out_ovf;
  logic [W-1:0] out_sum;
  logic         in_ready_24, out_valid_24, out_cout_24, out_ovf_24;
  logic [W-1:0] out_sum_24;
  logic         in_ready_1, out_valid_1, out_cout_1, out_ovf_1;
  logic [W-1:0] out_sum_1;

  pipelined_select_adder #(.WIDTH(W), .BLK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  pipelined_select_adder #(.WIDTH(W), .BLK(24)) u_dut_b24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_24),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid_24), .out_ready(out_ready), .out_sum(out_sum_24),
    .out_cout(out_cout_24), .out_ovf(out_ovf_24)
  );

  pipelined_select_adder #(.WIDTH(W), .BLK(1)) u_dut_b1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid_1), .out_ready(out_ready), .out_sum(out_sum_1),
    .out_cout(out_cout_1), .out_ovf(out_ovf_1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W+1:0] exp_q[$];   // {ovf, cout, sum}
  int checks   = 0;
  int failures = 0;
  logic rand_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: A + (sub ? ~B : B) + (sub ? ~cin : cin) at full precision.
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] be;
    logic         ce;
    logic [W:0]   full;
    logic         ov;
    be   = sub ? ~b : b;
    ce   = sub ? ~cin : cin;
    full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
    ov   = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: pop and compare whenever a result transfers out
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {40'd0, out_sum}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("sum",       {40'd0, out_sum},    {40'd0, e[W-1:0]});
        check("cout",      {63'd0, out_cout},   {63'd0, e[W]});
        check("ovf",       {63'd0, out_ovf},    {63'd0, e[W+1]});
        check("b24_valid", {63'd0, out_valid_24}, 64'd1);
        check("b24_res",   {38'd0, out_ovf_24, out_cout_24, out_sum_24},
                           {38'd0, e});
        check("b1_valid",  {63'd0, out_valid_1}, 64'd1);
        check("b1_res",    {38'd0, out_ovf_1, out_cout_1, out_sum_1},
                           {38'd0, e});
      end
    end
    if (!rst && !out_valid && (out_valid_24 || out_valid_1))
      check("alt_extra_valid", {62'd0, out_valid_24, out_valid_1}, 64'd0);
  end

  // Random back-pressure while streaming.
  always @(posedge clk) begin
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------------------------------------------------------------------
  // Driver: offer one vector, hold until accepted, push its expectation
  // ---------------------------------------------------------------------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub,
                      input logic [W+1:0] e);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    if (in_ready) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    // Reset state
    #12; rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum",   {40'd0, out_sum},   64'd0);
    check("rst_cout_ovf",  {62'd0, out_cout, out_ovf}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    @(posedge clk); #1;

    // Wrap with latency check: stage-1 load at the accept edge, result
    // registered at the following edge.
    in_a = 24'hFFFFFF; in_b = 24'h000001; in_cin = 0; in_sub = 0;
    in_valid = 1'b1;
    @(negedge clk);
    check("wrap_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.push_back({1'b0, 1'b1, 24'h000000});
    @(posedge clk); #1; in_valid = 1'b0;
    check("lat_after_accept", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check("lat_second_edge", {63'd0, out_valid}, 64'd1);
    idle(2);

    // Signed overflow and subtraction
    send(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, {1'b1, 1'b0, 24'h800000});
    send(24'h000005, 24'h000007, 1'b0, 1'b1, {1'b0, 1'b0, 24'hFFFFFE});
    // Carry ripple through every block
    send(24'h0FFFFF, 24'h000000, 1'b1, 1'b0, {1'b0, 1'b0, 24'h100000});
    // Subtract with borrow-in, no borrow out: 10 - 3 - 1 = 6
    send(24'h00000A, 24'h000003, 1'b1, 1'b1, {1'b0, 1'b1, 24'h000006});
    // Negative overflow on subtract: 0x800000 - 1
    send(24'h800000, 24'h000001, 1'b0, 1'b1, {1'b1, 1'b1, 24'h7FFFFF});
    idle(4);

    // Back-pressure: two fit, the third waits
    out_ready = 1'b0;
    send(24'd1, 24'd1, 1'b0, 1'b0, {2'b00, 24'd2});
    send(24'd2, 24'd2, 1'b0, 1'b0, {2'b00, 24'd4});
    // Offer and withdraw a vector while full: must not be captured
    in_a = 24'h0ABCDE; in_b = 24'h012345; in_valid = 1'b1;
    idle(2);
    in_valid = 1'b0;
    in_a = 24'd3; in_b = 24'd3; in_cin = 0; in_sub = 0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      check("bp_hold_sum", {40'd0, out_sum}, 64'd2);
      check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.push_back({2'b00, 24'd6});
    check("bp_stream0_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check("bp_stream1_valid", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    check("bp_stream2_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    idle(2);

    // Reset mid-flight
    out_ready = 1'b0;
    send(24'h000010, 24'h000020, 1'b0, 1'b0, {2'b00, 24'h000030});
    send(24'h000100, 24'h000200, 1'b0, 1'b0, {2'b00, 24'h000300});
    #2; rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_out_sum",   {40'd0, out_sum},   64'd0);
    check("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;

    // Random streaming with random gaps and random back-pressure
    rand_mode = 1'b1;
    for (int v = 0; v < 10000; v++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;

    // Drain
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
